// File: rtl/aes_tbox_pipe_if.sv
// Valid/ready bus for the AES T-table lookup pipeline: input beat channel,
// output beat channel and the busy status.
interface aes_tbox_pipe_if #(
    parameter int LANES = 4,
    parameter int TAG_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [32*LANES-1:0]   in_state;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [32*LANES-1:0]   out_p0;
    logic [32*LANES-1:0]   out_p1;
    logic [32*LANES-1:0]   out_p2;
    logic [32*LANES-1:0]   out_p3;
    logic                  out_mode;
    logic [TAG_W-1:0]      out_tag;
    logic                  busy;

    modport master (
        output in_valid, in_mode, in_state, in_tag, out_ready,
        input  in_ready, out_valid, out_p0, out_p1, out_p2, out_p3, out_mode, out_tag, busy
    );

    modport slave (
        input  in_valid, in_mode, in_state, in_tag, out_ready,
        output in_ready, out_valid, out_p0, out_p1, out_p2, out_p3, out_mode, out_tag, busy
    );
endinterface

// File: rtl/aes_tbox_pipe.sv
// Two-stage multi-lane AES lookup: stage 1 registers S-box and xtime(S-box),
// stage 2 forms the rotated T-table words (or plain SubWord) with stall control.
module aes_tbox_pipe #(
    parameter int LANES = 4,
    parameter int TAG_W = 4
) (
    input logic             clk,
    input logic             rst_n,
    aes_tbox_pipe_if.slave  bus
);

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        // Entry 0 sits in the top byte of each row.
        return 8'(row >> {~x[3:0], 3'b000});
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    endfunction

    logic                        adv_out;
    logic                        adv_s1;
    logic                        s1_valid;
    logic                        s1_mode;
    logic [TAG_W-1:0]            s1_tag;
    logic [LANES-1:0][3:0][7:0]  s1_s;
    logic [LANES-1:0][3:0][7:0]  s1_xs;
    logic [LANES-1:0][3:0][7:0]  lk_s;
    logic [LANES-1:0][3:0][7:0]  lk_xs;
    logic [32*LANES-1:0]         nx_p0, nx_p1, nx_p2, nx_p3;
    logic [LANES-1:0][3:0][7:0]  t3;
    logic                        out_valid_q;
    logic                        out_mode_q;
    logic [TAG_W-1:0]            out_tag_q;
    logic [32*LANES-1:0]         out_p0_q, out_p1_q, out_p2_q, out_p3_q;

    assign adv_out      = !out_valid_q || bus.out_ready;
    assign adv_s1       = !s1_valid || adv_out;
    assign bus.in_ready = adv_s1;

    always_comb begin
        lk_s  = '0;
        lk_xs = '0;
        for (int unsigned c = 0; c < LANES; c++) begin
            for (int unsigned b = 0; b < 4; b++) begin
                lk_s[c][b]  = sbox(bus.in_state[32*c + 8*(3-b) +: 8]);
                lk_xs[c][b] = xtime(lk_s[c][b]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (adv_s1) begin
            s1_valid <= bus.in_valid;
            s1_mode  <= bus.in_mode;
            s1_tag   <= bus.in_tag;
            s1_s     <= lk_s;
            s1_xs    <= lk_xs;
        end
    end

    always_comb begin
        nx_p0 = '0;
        nx_p1 = '0;
        nx_p2 = '0;
        nx_p3 = '0;
        t3    = s1_s ^ s1_xs;
        for (int unsigned c = 0; c < LANES; c++) begin
            if (s1_mode) begin
                nx_p0[32*c +: 32] = {s1_s[c][0], s1_s[c][1], s1_s[c][2], s1_s[c][3]};
            end else begin
                nx_p0[32*c +: 32] = {s1_xs[c][0], s1_s[c][0], s1_s[c][0], t3[c][0]};
                nx_p1[32*c +: 32] = {t3[c][1], s1_xs[c][1], s1_s[c][1], s1_s[c][1]};
                nx_p2[32*c +: 32] = {s1_s[c][2], t3[c][2], s1_xs[c][2], s1_s[c][2]};
                nx_p3[32*c +: 32] = {s1_s[c][3], s1_s[c][3], t3[c][3], s1_xs[c][3]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_mode_q  <= 1'b0;
            out_tag_q   <= '0;
            out_p0_q    <= '0;
            out_p1_q    <= '0;
            out_p2_q    <= '0;
            out_p3_q    <= '0;
        end else if (adv_out) begin
            out_valid_q <= s1_valid;
            out_mode_q  <= s1_mode;
            out_tag_q   <= s1_tag;
            out_p0_q    <= nx_p0;
            out_p1_q    <= nx_p1;
            out_p2_q    <= nx_p2;
            out_p3_q    <= nx_p3;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_mode  = out_mode_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_p0    = out_p0_q;
    assign bus.out_p1    = out_p1_q;
    assign bus.out_p2    = out_p2_q;
    assign bus.out_p3    = out_p3_q;
    assign bus.busy      = s1_valid || out_valid_q;

endmodule
